// File: rtl/zjh_arith_pkg.sv
// Shared definitions for the arithmetic lab datapath blocks.
//   state_t   : sequencer states for the bit-serial units (2-bit encoding)
//   W_DEF     : default operand width
//   cnt_width : bit-counter width for a given operand width (ceil(log2 W), min 1)
package zjh_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int W_DEF = 4;

    function automatic int cnt_width(input int w);
        if (w <= 2) return 1;
        return $clog2(w);
    endfunction

endpackage

// File: rtl/zjh_full_sub.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
//   a, b  : operand bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module zjh_full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/zjh_serial_sub.sv
// Bit-serial W-bit subtractor, D = A - B - Bin, LSB first, one bit per clock.
//   clk, rst_n   : system clock (rising edge), async active-low reset
//   start        : request, accepted when not busy (IDLE or DONE)
//   A, B, Bin    : operands, captured on the accepting edge
//   busy         : high while the bit loop runs
//   done         : one-cycle completion pulse
//   D, Bout, ov  : difference, unsigned borrow-out, signed overflow;
//                  updated only on completion and held otherwise
//
// state | meaning
// IDLE  | waiting for start
// RUN   | consuming one operand bit per clock
// DONE  | result just registered; done pulse; may accept a new start
module zjh_serial_sub
    import zjh_arith_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] D,
    output logic         Bout,
    output logic         ov
);

    localparam int             CW       = cnt_width(W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           br_q, br_d;
    logic           a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic           bout_q, bout_d, ov_q, ov_d;

    logic           fs_d, fs_bout;
    logic           accept, last;
    logic [W-1:0]   res_next;

    zjh_full_sub u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // A request is taken in IDLE and also in DONE, so back-to-back ops cost W+1 cycles.
    assign accept   = start && (state_q != RUN);
    assign last     = (state_q == RUN) && (cnt_q == CNT_LAST);
    assign res_next = {fs_d, res_q[W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        D    = d_q;
        Bout = bout_q;
        ov   = ov_q;
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ov_d    = ov_q;
        if (accept) begin
            a_d     = A;
            b_d     = B;
            br_d    = Bin;
            cnt_d   = '0;
            res_d   = '0;
            // Operand MSBs are kept aside because the shift registers lose them.
            a_msb_d = A[W-1];
            b_msb_d = B[W-1];
        end else if (state_q == RUN) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = fs_bout;
            cnt_d = cnt_q + CW'(1);
            res_d = res_next;
            if (last) begin
                d_d    = res_next;
                bout_d = fs_bout;
                ov_d   = (a_msb_q != b_msb_q) && (res_next[W-1] != a_msb_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_zjh_serial_sub.sv
// Directed bench for zjh_serial_sub (W=4) with a result scoreboard.
module tb_zjh_serial_sub;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A, B;
    logic         Bin;
    logic         busy, done, Bout, ov;
    logic [W-1:0] D;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    zjh_serial_sub #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout),
        .ov    (ov)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int a, input int b, input int bin);
        exp_t e;
        int   u, sa, sbv, s;
        u      = a - b - bin;
        e.d    = u[W-1:0];
        e.bout = (u < 0);
        sa     = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sbv    = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        s      = sa - sbv - bin;
        e.ov   = (s < -(1 << (W-1))) || (s > (1 << (W-1)) - 1);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_D"},    32'(D),    32'(e.d));
            check({tag, "_Bout"}, 32'(Bout), 32'(e.bout));
            check({tag, "_ov"},   32'(ov),   32'(e.ov));
        end
    endtask

    // Sampled #1 after an edge with done low; returns cycles until done (or budget).
    task automatic wait_done(input int budget, output int n, output int busy_cnt);
        n = 0;
        busy_cnt = 0;
        while (!done && n < budget) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input int a, input int b, input int bin);
        int n, bc;
        exp_t e;
        @(negedge clk);
        A = W'(a); B = W'(b); Bin = bin[0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 'x; B = 'x; Bin = 1'bx;
        e = model(a, b, bin);
        sb.push_back(e);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(W + 3, n, bc);
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(W));
        check_out(tag);
        @(posedge clk); #1;
        check({tag, "_done_single"}, 32'(done), 32'd0);
        check({tag, "_hold_D"}, 32'(D), 32'(e.d));
    endtask

    initial begin
        int   n, bc, pulses;
        exp_t e1;

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_D",    32'(D),    32'd0);
        check("rst_Bout", 32'(Bout), 32'd0);
        check("rst_ov",   32'(ov),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("op_9_5",    9, 5, 0);
        run_op("op_3_5",    3, 5, 0);
        run_op("op_8_1",    8, 1, 0);
        run_op("op_0_15_1", 0, 15, 1);

        // start held through RUN with new operands; taken only in the DONE cycle
        @(negedge clk);
        A = 4'd9; B = 4'd5; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        e1 = model(9, 5, 0);
        sb.push_back(e1);
        A = 4'd12; B = 4'd2; Bin = 1'b0;
        wait_done(W + 3, n, bc);
        check("b2b_first_latency", 32'(n), 32'(W));
        check("b2b_done_not_busy", 32'(busy), 32'd0);
        sb.push_back(model(12, 2, 0));
        check_out("b2b_first");
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_second_accepted", 32'(busy), 32'd1);
        check("b2b_hold_D_in_run", 32'(D), 32'(e1.d));
        wait_done(W + 3, n, bc);
        check("b2b_second_latency", 32'(n + 1), 32'(W + 1));
        check_out("b2b_second");

        // abort with reset after two RUN cycles
        @(negedge clk);
        A = 4'd9; B = 4'd5; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_D",    32'(D),    32'd0);
        check("abort_Bout", 32'(Bout), 32'd0);
        check("abort_ov",   32'(ov),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_D", 32'(D), 32'd0);

        run_op("op_6_6", 6, 6, 0);

        for (int i = 0; i < 6; i++) begin
            int ra, rb, rc;
            ra = int'($urandom_range(0, (1 << W) - 1));
            rb = int'($urandom_range(0, (1 << W) - 1));
            rc = int'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d_%0d_%0d_%0d", i, ra, rb, rc), ra, rb, rc);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
